// File: rtl/softmax_pkg.sv
// softmax_pkg: shared widths, element type and sequencer state encoding for the softmax streaming wrapper.
package softmax_pkg;
    localparam int DEF_DATA_W = 17;
    localparam int DEF_N      = 5;
    localparam int IDX_W      = $clog2(DEF_N);

    typedef logic [DEF_DATA_W-1:0] elem_t;

    typedef enum logic [1:0] {
        COLLECT,
        EVAL,
        DRAIN
    } state_t;
endpackage

// File: rtl/softmax_stream_sequencer.sv
// softmax_stream_sequencer: gathers a serial score frame into a parallel vector for the softmax core,
// captures the core's results and replays them as a serial stream.
module softmax_stream_sequencer
    import softmax_pkg::*;
#(
    parameter int                 DATA_W  = DEF_DATA_W,
    parameter int                 N       = DEF_N,
    parameter logic [DATA_W-1:0]  PAD_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_last,
    output logic [N*DATA_W-1:0]   core_x,
    input  logic [N*DATA_W-1:0]   core_sm,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic [IDX_W-1:0]      m_idx,
    output logic                  m_last,
    output logic                  err_short,
    output logic                  err_long
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      wr_q, wr_d, rd_q, rd_d, mi_q, mi_d, nxt;
    logic [N*DATA_W-1:0]   x_q, x_d, res_q, res_d;
    logic [DATA_W-1:0]     md_q, md_d;
    logic                  rdy_q, rdy_d, mv_q, mv_d, ml_q, ml_d, es_q, es_d, el_q, el_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            wr_q    <= '0;
            rd_q    <= '0;
            mi_q    <= '0;
            x_q     <= '0;
            res_q   <= '0;
            md_q    <= '0;
            rdy_q   <= 1'b0;
            mv_q    <= 1'b0;
            ml_q    <= 1'b0;
            es_q    <= 1'b0;
            el_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mi_q    <= mi_d;
            x_q     <= x_d;
            res_q   <= res_d;
            md_q    <= md_d;
            rdy_q   <= rdy_d;
            mv_q    <= mv_d;
            ml_q    <= ml_d;
            es_q    <= es_d;
            el_q    <= el_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        mi_d    = mi_q;
        x_d     = x_q;
        res_d   = res_q;
        md_d    = md_q;
        mv_d    = mv_q;
        ml_d    = ml_q;
        es_d    = 1'b0;
        el_d    = 1'b0;
        nxt     = rd_q + 1'b1;
        case (state_q)
            COLLECT: begin
                if (s_valid && rdy_q) begin
                    // an early s_last pads every slot above the one being written
                    for (int i = 0; i < N; i++) begin
                        if (i == int'(wr_q))
                            x_d[i*DATA_W +: DATA_W] = s_data;
                        else if (s_last && i > int'(wr_q))
                            x_d[i*DATA_W +: DATA_W] = PAD_VAL;
                    end
                    wr_d = wr_q + 1'b1;
                    if (s_last || wr_q == LAST) begin
                        state_d = EVAL;
                        wr_d    = '0;
                        es_d    = s_last && (wr_q != LAST);
                        el_d    = !s_last && (wr_q == LAST);
                    end
                end
            end
            EVAL: begin
                res_d   = core_sm;
                rd_d    = '0;
                mv_d    = 1'b1;
                md_d    = core_sm[DATA_W-1:0];
                mi_d    = '0;
                ml_d    = (LAST == '0);
                state_d = DRAIN;
            end
            DRAIN: begin
                if (m_ready) begin
                    if (rd_q == LAST) begin
                        state_d = COLLECT;
                        mv_d    = 1'b0;
                        ml_d    = 1'b0;
                        rd_d    = '0;
                    end else begin
                        rd_d = nxt;
                        mi_d = nxt;
                        md_d = res_q[nxt*DATA_W +: DATA_W];
                        ml_d = (nxt == LAST);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
        rdy_d = (state_d == COLLECT);
    end

    assign s_ready   = rdy_q;
    assign core_x    = x_q;
    assign m_valid   = mv_q;
    assign m_data    = md_q;
    assign m_idx     = mi_q;
    assign m_last    = ml_q;
    assign err_short = es_q;
    assign err_long  = el_q;
endmodule

// File: tb/tb_softmax_stream_sequencer.sv
// tb_softmax_stream_sequencer: directed frames through the sequencer with an XOR loopback core stub.
module tb_softmax_stream_sequencer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
    logic [16:0]  s_data = '0;
    logic         s_ready, m_valid, m_last, err_short, err_long;
    logic [16:0]  m_data;
    logic [2:0]   m_idx;
    logic [84:0]  core_x, core_sm;
    int           checks = 0, errors = 0;

    assign core_sm = core_x ^ {5{17'h10000}};

    always #5 clk = ~clk;

    softmax_stream_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .core_x(core_x), .core_sm(core_sm),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
        .err_short(err_short), .err_long(err_long)
    );

    task automatic chk(input string tag, input logic [84:0] obs, input logic [84:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at a negedge while s_ready is high; returns at the following negedge
    task automatic send(input logic [16:0] d, input logic l);
        chk("s_ready_before_send", 85'(s_ready), 85'(1'b1));
        s_valid = 1'b1; s_data = d; s_last = l;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_data = 17'h1ffff;
    endtask

    // called at the negedge just after the final accept (EVAL state)
    task automatic drain(input logic [4:0][16:0] exp, input int stall_idx, input int stall_n);
        chk("lat_mvalid_eval", 85'(m_valid), 85'(1'b0));
        chk("lat_sready_eval", 85'(s_ready), 85'(1'b0));
        m_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k == stall_idx) begin
                m_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_data", 85'(m_data), 85'(exp[k]));
                    chk("stall_idx", 85'(m_idx), 85'(k));
                    chk("stall_valid", 85'(m_valid), 85'(1'b1));
                    chk("stall_sready", 85'(s_ready), 85'(1'b0));
                end
                m_ready = 1'b1;
            end
            chk("m_valid", 85'(m_valid), 85'(1'b1));
            chk("m_data", 85'(m_data), 85'(exp[k]));
            chk("m_idx", 85'(m_idx), 85'(k));
            chk("m_last", 85'(m_last), 85'(k == 4));
            chk("s_ready_drain", 85'(s_ready), 85'(1'b0));
            chk("no_err_pulse", 85'({err_short, err_long}), 85'(2'b00));
            @(negedge clk);
        end
        chk("m_valid_after", 85'(m_valid), 85'(1'b0));
        chk("s_ready_after", 85'(s_ready), 85'(1'b1));
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 85'(s_ready), 85'(1'b0));
        chk("rst_outputs", 85'({m_valid, m_data, m_idx, m_last, err_short, err_long}), 85'(0));
        chk("rst_core_x", core_x, 85'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_s_ready", 85'(s_ready), 85'(1'b1));

        // nominal frame
        for (int i = 1; i <= 5; i++) send(17'(i), i == 5);
        chk("nom_core_x", core_x, {17'h5, 17'h4, 17'h3, 17'h2, 17'h1});
        drain({17'h10005, 17'h10004, 17'h10003, 17'h10002, 17'h10001}, -1, 0);

        // backpressure on idx 2
        for (int i = 1; i <= 5; i++) send(17'(i), i == 5);
        drain({17'h10005, 17'h10004, 17'h10003, 17'h10002, 17'h10001}, 2, 3);

        // short frame, padding overwrites stale slots 3 and 4
        send(17'h0000A, 1'b0);
        send(17'h0000B, 1'b0);
        send(17'h0000C, 1'b1);
        chk("short_err", 85'({err_short, err_long}), 85'(2'b10));
        chk("short_core_x", core_x, {17'h0, 17'h0, 17'hC, 17'hB, 17'hA});
        drain({17'h10000, 17'h10000, 17'h1000C, 17'h1000B, 17'h1000A}, -1, 0);

        // long frame, then the following score starts a new frame
        for (int i = 0; i < 5; i++) send(17'h21 + 17'(i), 1'b0);
        chk("long_err", 85'({err_short, err_long}), 85'(2'b01));
        drain({17'h10025, 17'h10024, 17'h10023, 17'h10022, 17'h10021}, -1, 0);
        send(17'h00077, 1'b0);
        chk("long_next_noerr", 85'({err_short, err_long}), 85'(2'b00));
        for (int i = 0; i < 4; i++) send(17'h78 + 17'(i), i == 3);
        drain({17'h1007B, 17'h1007A, 17'h10079, 17'h10078, 17'h10077}, -1, 0);

        // reset while draining idx 2
        for (int i = 1; i <= 5; i++) send(17'h40 + 17'(i), i == 5);
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_idx", 85'(m_idx), 85'(2));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mvalid", 85'(m_valid), 85'(1'b0));
        chk("rst_mid_sready", 85'(s_ready), 85'(1'b0));
        chk("rst_mid_core_x", core_x, 85'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel2_sready", 85'(s_ready), 85'(1'b1));
        chk("rel2_mvalid", 85'(m_valid), 85'(1'b0));
        for (int i = 1; i <= 5; i++) send(17'h30 + 17'(i), i == 5);
        drain({17'h10035, 17'h10034, 17'h10033, 17'h10032, 17'h10031}, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
